addsub_pipe: RTL

// - Parametrised pipelined adder/subtractor; generalises the 4-bit ripple full-adder to WIDTH bits.
// - Splits the carry chain into STAGES registered ripple segments for timing closure.
// - Adds a valid/ready stream interface with backpressure, a per-operation add/sub mode, and carry/overflow flags.
// - Sits between operand producers (register file, ALU issue) and the result consumer in the datapath.

---
 rtl/addsub_if.sv | 26 ++
 rtl/addsub_pipe.sv | 105 ++++++++++
 2 files changed

// File: rtl/addsub_if.sv
// Operand/result stream bundle for addsub_pipe: a valid/ready operand beat in,
// and a valid/ready result beat out with carry and signed-overflow flags.
interface addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Co;
   logic             Ovf;

   modport master (
      output in_valid, A, B, Sub, out_ready,
      input  in_ready, out_valid, S, Co, Ovf
   );

   modport slave (
      input  in_valid, A, B, Sub, out_ready,
      output in_ready, out_valid, S, Co, Ovf
   );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES ripple segments.
// Optional signed saturation of S on overflow when ADDSUB_PIPE_SAT_EN is defined.
module addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic     clk,
   input  logic     reset,
   addsub_if.slave  bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic out_vld;
   logic adv;

   // One global enable: the whole pipe moves whenever the output slot is free or being taken.
   assign adv          = !out_vld || bus.out_ready;
   assign bus.in_ready = adv;

`ifdef ADDSUB_PIPE_SAT_EN
   function automatic logic [WIDTH-1:0] sat_value(input logic neg);
      sat_value = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // IW: operand bits not yet summed on entry; SW: result bits complete after this stage.
      localparam int IW = WIDTH - k*CHUNK;
      localparam int SW = (k+1)*CHUNK;

      logic [IW-1:0]  a_in;
      logic [IW-1:0]  bx_in;
      logic           c_in;
      logic           v_in;
      logic [CHUNK:0] sum;
      logic [SW-1:0]  s_nxt;
      logic           vld_p;
      logic           c_p;
      logic [SW-1:0]  s_p;

      if (k == 0) begin : g_first
         assign a_in  = bus.A;
         assign bx_in = bus.Sub ? ~bus.B : bus.B;
         assign c_in  = bus.Sub;
         assign v_in  = bus.in_valid;
         assign s_nxt = sum[CHUNK-1:0];
      end else begin : g_next
         assign a_in  = g_stage[k-1].g_mid.a_p;
         assign bx_in = g_stage[k-1].g_mid.bx_p;
         assign c_in  = g_stage[k-1].c_p;
         assign v_in  = g_stage[k-1].vld_p;
         assign s_nxt = {sum[CHUNK-1:0], g_stage[k-1].s_p};
      end

      assign sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bx_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

      always_ff @(posedge clk) begin
         if (reset) begin
            vld_p <= 1'b0;
         end else if (adv) begin
            vld_p <= v_in;
         end
      end

      if (k < STAGES-1) begin : g_mid
         // ---- stage k -> k+1 boundary: upper operand bits ride along with the partial sum
         logic [IW-CHUNK-1:0] a_p;
         logic [IW-CHUNK-1:0] bx_p;

         always_ff @(posedge clk) begin
            if (adv) begin
               a_p  <= a_in[IW-1:CHUNK];
               bx_p <= bx_in[IW-1:CHUNK];
               c_p  <= sum[CHUNK];
               s_p  <= s_nxt;
            end
         end
      end else begin : g_last
         // ---- output boundary: final carry, overflow flag and (optionally) clamped sum
         logic ovf_nxt;
         logic ovf_p;

         assign ovf_nxt = (a_in[IW-1] == bx_in[IW-1]) && (s_nxt[SW-1] != a_in[IW-1]);

         always_ff @(posedge clk) begin
            if (adv) begin
               c_p   <= sum[CHUNK];
               ovf_p <= ovf_nxt;
`ifdef ADDSUB_PIPE_SAT_EN
               s_p   <= ovf_nxt ? sat_value(a_in[IW-1]) : s_nxt;
`else
               s_p   <= s_nxt;
`endif
            end
         end
      end
   end

   // Data registers are not reset, so result fields are masked to zero when no beat is presented.
   assign out_vld       = g_stage[STAGES-1].vld_p;
   assign bus.out_valid = out_vld;
   assign bus.S         = out_vld ? g_stage[STAGES-1].s_p : '0;
   assign bus.Co        = out_vld && g_stage[STAGES-1].c_p;
   assign bus.Ovf       = out_vld && g_stage[STAGES-1].g_last.ovf_p;
endmodule
